uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receiver; the downstream peer of the transmitter block.
//   Samples an async 8N1 line (idle high, 1 start, 8 data LSB-first, 1 stop) at
//   CLOCKS_PER_PULSE clocks per bit.
//   Presents each received byte with a one-cycle valid strobe and flags framing errors.
// PARAMETERS
//   CLOCKS_PER_PULSE  16  clk cycles per bit; must be even and >= 4
//                         (HALF = CLOCKS_PER_PULSE/2)
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  asynchronous, active-high reset
//   rx          in   1  serial line, asynchronous to clk, idle high
//   data_out    out  8  last good byte; holds until the next good frame
//   data_valid  out  1  one-cycle pulse: data_out updated this cycle
//   frame_err   out  1  one-cycle pulse: stop bit sampled low
//   rx_busy     out  1  high whenever state != RX_IDLE (combinational)
// BEHAVIOUR
//   Reset: one clock; rst asynchronous, active-high. Reset applies at any time,
//     including mid-frame, and values are:
//     - sync flops = 1; state = RX_IDLE; counters = 0; shift reg = 0
//     - data_out = 8'h00; data_valid = 0; frame_err = 0; rx_busy = 0
//   Input sync: rx passes through 2 flops -> rx_s. FSM uses only rx_s.
//   c_clocks is $clog2(CLOCKS_PER_PULSE) bits. c_bits is 3 bits.
//   RX_IDLE: on rx_s == 0 -> RX_START, c_clocks = 0, c_bits = 0.
//   RX_START: c_clocks increments. When c_clocks == HALF-1, sample rx_s (mid start bit):
//     - rx_s == 0 -> RX_DATA, c_clocks = 0
//     - rx_s == 1 -> glitch -> RX_IDLE, no strobe
//   RX_DATA: c_clocks counts to CLOCKS_PER_PULSE-1, then sets shreg[c_bits] = rx_s
//     and c_clocks = 0.
//     - c_bits == 7 -> RX_STOP
//     - else c_bits + 1
//   RX_STOP: at c_clocks == CLOCKS_PER_PULSE-1, sample rx_s:
//     - 1 -> data_out = shreg, data_valid = 1 for one cycle, -> RX_IDLE
//     - 0 -> frame_err = 1 for one cycle, data_out unchanged, -> RX_RECOVER
//   RX_RECOVER: waits for rx_s == 1 (break/stuck-low line), then -> RX_IDLE.
//     No new frame is accepted while in this state.
//   Latency: let edge 0 be the first posedge at which the first sync flop captures 0.
//     - data_valid is high after edge 2 + HALF + 9*CLOCKS_PER_PULSE
//     - that is edge 154 at the default
//   Back-to-back frames: RX_IDLE is re-entered at mid stop bit, so a start bit that
//     follows a full-length stop bit is detected without loss.
//   data_valid and frame_err are never high in the same cycle.
//   No handshake or backpressure: the consumer must take data_out on data_valid.
//   Each good frame overwrites data_out.
// STRUCTURE
//   uart_pkg:
//     - typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t
//     - localparam DEFAULT_CLOCKS_PER_PULSE = 16 (shared with the transmitter)
//   Sub-module uart_rx_sync: 2-flop synchronizer, reset value 1.
//   The FSM and datapath sit in uart_receiver.
// TESTING (CLOCKS_PER_PULSE = 16 unless noted)
//   1. Drive frame 0xA5 -> data_out = 8'hA5, data_valid high for exactly 1 cycle at
//      edge 154, frame_err = 0, rx_busy low the cycle after.
//   2. rx low for 4 cycles, then high -> no data_valid and no frame_err;
//      rx_busy falls by edge 10; a following 0x3C frame is received correctly.
//   3. Frame 0x5A with stop bit driven 0 for 3 bits, then 1:
//      - frame_err pulses once; data_out keeps the prior value (0x3C)
//      - state stays RX_RECOVER until the line is high
//      - the next frame 0x81 is received correctly
//   4. Back-to-back 0x00, 0xFF, 0x55 with 1-bit stop and no idle gap -> three
//      data_valid pulses 160 cycles apart, correct bytes.
//   5. Assert rst during data bit 4 of a frame -> all outputs at reset values while
//      rst is high; after release with the line idle, frame 0xC3 is received correctly.
//   6. Loopback from the transmitter block, CLOCKS_PER_PULSE = 4, 256 random bytes ->
//      every byte matches; zero frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rx_state_t;

  localparam int DEFAULT_CLOCKS_PER_PULSE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments make both flops sample the pre-edge values,
  // which is what builds a two-stage pipeline instead of a single wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling FSM, one-cycle data/framing strobes and
// a recovery state that holds off new frames while the line is held low.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW   = $clog2(CLOCKS_PER_PULSE);
  localparam int HALF = CLOCKS_PER_PULSE / 2;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] MID_CLK  = CW'(HALF - 1);

  logic            w_rx_s;
  rx_state_t       r_state,  w_state_next;
  logic [CW-1:0]   r_clocks, w_clocks_next;
  logic [2:0]      r_bits,   w_bits_next;
  logic [7:0]      r_shreg,  w_shreg_next;
  logic [7:0]      r_data,   w_data_next;
  logic            r_valid,  w_valid_next;
  logic            r_ferr,   w_ferr_next;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RX_IDLE;
      r_clocks <= '0;
      r_bits   <= '0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_clocks <= w_clocks_next;
      r_bits   <= w_bits_next;
      r_shreg  <= w_shreg_next;
      r_data   <= w_data_next;
      r_valid  <= w_valid_next;
      r_ferr   <= w_ferr_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_state_next  = r_state;
    w_clocks_next = r_clocks;
    w_bits_next   = r_bits;
    w_shreg_next  = r_shreg;
    w_data_next   = r_data;
    w_valid_next  = 1'b0;
    w_ferr_next   = 1'b0;

    unique case (r_state)
      RX_IDLE: begin
        if (!w_rx_s) begin
          w_state_next  = RX_START;
          w_clocks_next = '0;
          w_bits_next   = '0;
        end
      end

      RX_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (r_clocks == MID_CLK) begin
          w_clocks_next = '0;
          w_state_next  = w_rx_s ? RX_IDLE : RX_DATA;
        end else begin
          w_clocks_next = r_clocks + 1'b1;
        end
      end

      RX_DATA: begin
        if (r_clocks == LAST_CLK) begin
          w_clocks_next        = '0;
          w_shreg_next[r_bits] = w_rx_s;
          if (r_bits == 3'd7) w_state_next = RX_STOP;
          else                w_bits_next  = r_bits + 3'd1;
        end else begin
          w_clocks_next = r_clocks + 1'b1;
        end
      end

      RX_STOP: begin
        if (r_clocks == LAST_CLK) begin
          w_clocks_next = '0;
          if (w_rx_s) begin
            w_data_next  = r_shreg;
            w_valid_next = 1'b1;
            w_state_next = RX_IDLE;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = RX_RECOVER;
          end
        end else begin
          w_clocks_next = r_clocks + 1'b1;
        end
      end

      RX_RECOVER: begin
        if (w_rx_s) w_state_next = RX_IDLE;
      end

      default: w_state_next = RX_IDLE;
    endcase
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign rx_busy    = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a 16-clock instance for timing/error cases
// and a 4-clock instance fed by a behavioural transmitter for random loopback.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPP  = DEFAULT_CLOCKS_PER_PULSE;
  localparam int CPP4 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx4;
  logic [7:0] data_out,   data_out4;
  logic       data_valid, data_valid4;
  logic       frame_err,  frame_err4;
  logic       rx_busy,    rx_busy4;

  int n_checks = 0;
  int n_pass   = 0;

  uart_receiver #(.CLOCKS_PER_PULSE(CPP)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_out(data_out), .data_valid(data_valid),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_receiver #(.CLOCKS_PER_PULSE(CPP4)) dut4 (
    .clk(clk), .rst(rst), .rx(rx4),
    .data_out(data_out4), .data_valid(data_valid4),
    .frame_err(frame_err4), .rx_busy(rx_busy4)
  );

  always #5 clk = ~clk;

  // Posedge counter; read on negedges, so edge k after a start edge s reads s+k.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Event monitors: record every strobe with the edge it followed.
  int         v_edge[$];
  logic [7:0] v_data[$];
  logic       busy_after[$];
  int         f_edge[$];
  logic [7:0] v4_data[$];
  int         f4_cnt      = 0;
  int         overlap_cnt = 0;
  logic       prev_valid  = 1'b0;

  always @(negedge clk) begin
    if (prev_valid) busy_after.push_back(rx_busy);
    prev_valid <= (data_valid === 1'b1);
    if (data_valid === 1'b1) begin
      v_edge.push_back(edge_cnt);
      v_data.push_back(data_out);
    end
    if (frame_err === 1'b1) f_edge.push_back(edge_cnt);
    if (data_valid === 1'b1 && frame_err === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if (data_valid4 === 1'b1) v4_data.push_back(data_out4);
    if (frame_err4 === 1'b1) f4_cnt <= f4_cnt + 1;
    if (data_valid4 === 1'b1 && frame_err4 === 1'b1) overlap_cnt <= overlap_cnt + 1;
  end

  // Drives one frame; must be called right after a negedge, returns likewise.
  // start is the edge_cnt value after edge 0 (first sync-flop capture of 0).
  task automatic send_frame(input logic [7:0] b, input logic stop_val,
                            input int stop_bits, input bit to4, output int start);
    int cpp;
    cpp = to4 ? CPP4 : CPP;
    start = edge_cnt + 1;
    if (to4) rx4 = 1'b0; else rx = 1'b0;
    repeat (cpp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (to4) rx4 = b[i]; else rx = b[i];
      repeat (cpp) @(negedge clk);
    end
    if (to4) rx4 = stop_val; else rx = stop_val;
    repeat (cpp * stop_bits) @(negedge clk);
    if (to4) rx4 = 1'b1; else rx = 1'b1;
  endtask

  task automatic wait_until(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  function automatic logic [7:0] vdata_at(input int idx);
    return (idx < v_data.size()) ? v_data[idx] : 8'hxx;
  endfunction

  function automatic int vedge_at(input int idx);
    return (idx < v_edge.size()) ? v_edge[idx] : -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rx4 = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h want 00", data_out); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL reset_rx_busy: got %b want 0", rx_busy); else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int s, vb, fb, bb;
    vb = v_edge.size(); fb = f_edge.size(); bb = busy_after.size();
    send_frame(8'hA5, 1'b1, 1, 1'b0, s);
    repeat (10) @(negedge clk);
    n_checks++; if (v_edge.size() - vb != 1) $display("FAIL single_pulses: got %0d want 1", v_edge.size() - vb); else n_pass++;
    n_checks++; if (vdata_at(vb) !== 8'hA5) $display("FAIL single_data: got %h want a5", vdata_at(vb)); else n_pass++;
    n_checks++; if (vedge_at(vb) != s + 154) $display("FAIL single_latency: got edge %0d want %0d", vedge_at(vb) - s, 154); else n_pass++;
    n_checks++; if (f_edge.size() != fb) $display("FAIL single_frame_err: got %0d want 0", f_edge.size() - fb); else n_pass++;
    n_checks++;
    if (busy_after.size() <= bb || busy_after[bb] !== 1'b0) $display("FAIL single_busy_after: got %b want 0", (busy_after.size() > bb) ? busy_after[bb] : 1'bx);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int s, vb, fb;
    vb = v_edge.size(); fb = f_edge.size();
    s = edge_cnt + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    wait_until(s + 5);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_mid: got %b want 1", rx_busy); else n_pass++;
    wait_until(s + 10);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_busy_fall: got %b want 0", rx_busy); else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++; if (v_edge.size() != vb) $display("FAIL glitch_no_valid: got %0d want 0", v_edge.size() - vb); else n_pass++;
    n_checks++; if (f_edge.size() != fb) $display("FAIL glitch_no_ferr: got %0d want 0", f_edge.size() - fb); else n_pass++;
    send_frame(8'h3C, 1'b1, 1, 1'b0, s);
    repeat (10) @(negedge clk);
    n_checks++; if (vdata_at(vb) !== 8'h3C || v_edge.size() - vb != 1) $display("FAIL glitch_next_frame: got %h (%0d pulses) want 3c (1)", vdata_at(vb), v_edge.size() - vb); else n_pass++;
    n_checks++; if (vedge_at(vb) != s + 154) $display("FAIL glitch_next_latency: got %0d want 154", vedge_at(vb) - s); else n_pass++;
  endtask

  task automatic test_frame_err();
    int s, vb, fb;
    vb = v_edge.size(); fb = f_edge.size();
    send_frame(8'h5A, 1'b0, 3, 1'b0, s);
    n_checks++; if (rx_busy !== 1'b1) $display("FAIL ferr_recover_busy: got %b want 1", rx_busy); else n_pass++;
    n_checks++; if (f_edge.size() - fb != 1) $display("FAIL ferr_pulses: got %0d want 1", f_edge.size() - fb); else n_pass++;
    n_checks++; if (f_edge.size() <= fb || f_edge[fb] != s + 154) $display("FAIL ferr_latency: got %0d want 154", (f_edge.size() > fb) ? f_edge[fb] - s : -1); else n_pass++;
    n_checks++; if (v_edge.size() != vb) $display("FAIL ferr_no_valid: got %0d want 0", v_edge.size() - vb); else n_pass++;
    n_checks++; if (data_out !== 8'h3C) $display("FAIL ferr_data_hold: got %h want 3c", data_out); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL ferr_back_idle: got %b want 0", rx_busy); else n_pass++;
    send_frame(8'h81, 1'b1, 1, 1'b0, s);
    repeat (10) @(negedge clk);
    n_checks++; if (vdata_at(vb) !== 8'h81 || v_edge.size() - vb != 1) $display("FAIL ferr_next_frame: got %h (%0d pulses) want 81 (1)", vdata_at(vb), v_edge.size() - vb); else n_pass++;
    n_checks++; if (f_edge.size() - fb != 1) $display("FAIL ferr_extra_err: got %0d want 1", f_edge.size() - fb); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s0, s1, s2, vb;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    vb = v_edge.size();
    send_frame(exp_b[0], 1'b1, 1, 1'b0, s0);
    send_frame(exp_b[1], 1'b1, 1, 1'b0, s1);
    send_frame(exp_b[2], 1'b1, 1, 1'b0, s2);
    repeat (10) @(negedge clk);
    n_checks++; if (v_edge.size() - vb != 3) $display("FAIL b2b_pulses: got %0d want 3", v_edge.size() - vb); else n_pass++;
    n_checks++; if (vedge_at(vb) != s0 + 154) $display("FAIL b2b_first_latency: got %0d want 154", vedge_at(vb) - s0); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (vdata_at(vb + i) !== exp_b[i]) $display("FAIL b2b_data%0d: got %h want %h", i, vdata_at(vb + i), exp_b[i]); else n_pass++;
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++; if (vedge_at(vb + i) - vedge_at(vb + i - 1) != 160) $display("FAIL b2b_spacing%0d: got %0d want 160", i, vedge_at(vb + i) - vedge_at(vb + i - 1)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int s, vb, fb;
    b = 8'h96;
    n_checks++; if (data_out !== 8'h55) $display("FAIL rmid_pre_data: got %h want 55", data_out); else n_pass++;
    rx = 1'b0;
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPP) @(negedge clk);
    end
    rx = b[4];
    repeat (CPP / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (data_out !== 8'h00) $display("FAIL rmid_data_out: got %h want 00", data_out); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL rmid_data_valid: got %b want 0", data_valid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rmid_frame_err: got %b want 0", frame_err); else n_pass++;
    n_checks++; if (rx_busy !== 1'b0) $display("FAIL rmid_rx_busy: got %b want 0", rx_busy); else n_pass++;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_busy !== 1'b0 || data_out !== 8'h00) $display("FAIL rmid_held: got busy %b data %h want 0 00", rx_busy, data_out); else n_pass++;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    vb = v_edge.size(); fb = f_edge.size();
    send_frame(8'hC3, 1'b1, 1, 1'b0, s);
    repeat (10) @(negedge clk);
    n_checks++; if (vdata_at(vb) !== 8'hC3 || v_edge.size() - vb != 1) $display("FAIL rmid_next_frame: got %h (%0d pulses) want c3 (1)", vdata_at(vb), v_edge.size() - vb); else n_pass++;
    n_checks++; if (vedge_at(vb) != s + 154) $display("FAIL rmid_latency: got %0d want 154", vedge_at(vb) - s); else n_pass++;
    n_checks++; if (f_edge.size() != fb) $display("FAIL rmid_no_ferr: got %0d want 0", f_edge.size() - fb); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int s, vb, fb;
    vb = v4_data.size(); fb = f4_cnt;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1, 1'b1, s);
    end
    repeat (20) @(negedge clk);
    n_checks++; if (v4_data.size() - vb != 256) $display("FAIL loop_count: got %0d want 256", v4_data.size() - vb); else n_pass++;
    for (int i = 0; i < 256; i++) begin
      n_checks++;
      if (vb + i >= v4_data.size() || v4_data[vb + i] !== exp_q[i])
        $display("FAIL loop_byte%0d: got %h want %h", i, (vb + i < v4_data.size()) ? v4_data[vb + i] : 8'hxx, exp_q[i]);
      else n_pass++;
    end
    n_checks++; if (f4_cnt != fb) $display("FAIL loop_frame_err: got %0d want 0", f4_cnt - fb); else n_pass++;
  endtask

  task automatic test_exclusive();
    n_checks++; if (overlap_cnt != 0) $display("FAIL valid_ferr_overlap: got %0d want 0", overlap_cnt); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx4 = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
